// File: rtl/vp_stage.sv
// Video pixel stage: 3-cycle pipeline with passthrough/gray/binary/invert modes.
// Define VP_STAGE_BBOX_EN to compile in the bright-region bounding-box overlay (mode 4).
module vp_stage #(
    parameter int                 CH_W      = 8,
    parameter int                 THRESH    = 128,
    parameter int                 POS_W     = 11,
    parameter logic [3*CH_W-1:0]  BOX_COLOR = 24'hFF0000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                de_in,
    input  logic                h_sync_in,
    input  logic                v_sync_in,
    input  logic [3*CH_W-1:0]   pixel_in,
    input  logic [2:0]          sw,
    output logic                de_out,
    output logic                h_sync_out,
    output logic                v_sync_out,
    output logic [3*CH_W-1:0]   pixel_out
);
    localparam int PW = 3 * CH_W;
    localparam logic [CH_W-1:0] THR = CH_W'(THRESH);

    // Weighted sum fits in CH_W+8 bits, so no overflow before the >>8.
    function automatic logic [CH_W-1:0] luma_f(input logic [PW-1:0] p);
        logic [CH_W+7:0] r, g, b, sum;
        r   = {8'd0, p[PW-1 -: CH_W]};
        g   = {8'd0, p[2*CH_W-1 -: CH_W]};
        b   = {8'd0, p[CH_W-1:0]};
        sum = (CH_W+8)'(77) * r + (CH_W+8)'(150) * g + (CH_W+8)'(29) * b;
        return sum[CH_W+7:8];
    endfunction

    logic              vs_prev_r, frame_start_s;
    logic [2:0]        mode_r, mode0_s;
    logic [CH_W-1:0]   luma0_s;
    logic [PW-1:0]     pix1_r, pix2_r, result_s, bin_s;
    logic [CH_W-1:0]   luma1_r;
    logic [2:0]        mode1_r;
    logic              de1_r, hs1_r, vs1_r, de2_r, hs2_r, vs2_r;

    // Frame start detect; a frame-start pixel already uses the newly selected mode.
    always_comb begin
        frame_start_s = v_sync_in & ~vs_prev_r;
        luma0_s       = luma_f(pixel_in);
        if (frame_start_s) begin
            mode0_s = sw;
        end else begin
            mode0_s = mode_r;
        end
    end

    // Mode register, only reloaded at frame start.
    always_ff @(posedge clk) begin
        if (rst) begin
            vs_prev_r <= 1'b0;
            mode_r    <= 3'd0;
        end else begin
            vs_prev_r <= v_sync_in;
            mode_r    <= mode0_s;
        end
    end

`ifdef VP_STAGE_BBOX_EN
    logic              de_prev_r, bright0_s, hit_s, armed_r, found_r, valid_r;
    logic [POS_W-1:0]  x_r, y_r, x1_r, y1_r;
    logic [POS_W-1:0]  axmin_r, axmax_r, aymin_r, aymax_r;
    logic [POS_W-1:0]  dxmin_r, dxmax_r, dymin_r, dymax_r;

    always_comb begin
        bright0_s = luma0_s > THR;
    end

    // Position counters: x per active pixel, y per line end, both saturating.
    always_ff @(posedge clk) begin
        if (rst) begin
            de_prev_r <= 1'b0;
            x_r       <= '0;
            y_r       <= '0;
        end else begin
            de_prev_r <= de_in;
            if (de_in) begin
                x_r <= (x_r == {POS_W{1'b1}}) ? x_r : x_r + POS_W'(1);
            end else if (de_prev_r) begin
                x_r <= '0;
            end else begin
                x_r <= x_r;
            end
            if (frame_start_s) begin
                y_r <= '0;
            end else if (!de_in && de_prev_r) begin
                y_r <= (y_r == {POS_W{1'b1}}) ? y_r : y_r + POS_W'(1);
            end else begin
                y_r <= y_r;
            end
        end
    end

    // Box measured over one frame is shown during the next; armed_r hides the
    // partial first frame after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            axmin_r <= '1; axmax_r <= '0; aymin_r <= '1; aymax_r <= '0;
            dxmin_r <= '0; dxmax_r <= '0; dymin_r <= '0; dymax_r <= '0;
            found_r <= 1'b0;
            valid_r <= 1'b0;
            armed_r <= 1'b0;
        end else if (frame_start_s) begin
            dxmin_r <= axmin_r; dxmax_r <= axmax_r; dymin_r <= aymin_r; dymax_r <= aymax_r;
            valid_r <= found_r & armed_r;
            armed_r <= 1'b1;
            axmin_r <= '1; axmax_r <= '0; aymin_r <= '1; aymax_r <= '0;
            found_r <= 1'b0;
        end else if (de_in && bright0_s) begin
            axmin_r <= (x_r < axmin_r) ? x_r : axmin_r;
            axmax_r <= (x_r > axmax_r) ? x_r : axmax_r;
            aymin_r <= (y_r < aymin_r) ? y_r : aymin_r;
            aymax_r <= (y_r > aymax_r) ? y_r : aymax_r;
            found_r <= 1'b1;
        end else begin
            found_r <= found_r;
        end
    end

    // Pixel position travels with the pixel into stage 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            x1_r <= '0;
            y1_r <= '0;
        end else begin
            x1_r <= x_r;
            y1_r <= y_r;
        end
    end

    // Perimeter hit test against the displayed box.
    always_comb begin
        hit_s = valid_r &&
                ((((x1_r == dxmin_r) || (x1_r == dxmax_r)) && (y1_r >= dymin_r) && (y1_r <= dymax_r)) ||
                 (((y1_r == dymin_r) || (y1_r == dymax_r)) && (x1_r >= dxmin_r) && (x1_r <= dxmax_r)));
    end
`endif

    // Mode-dependent pixel transform on stage-1 data.
    always_comb begin
        bin_s = (luma1_r > THR) ? {PW{1'b1}} : {PW{1'b0}};
        case (mode1_r)
            3'd1:    result_s = {3{luma1_r}};
            3'd2:    result_s = bin_s;
            3'd3:    result_s = ~pix1_r;
`ifdef VP_STAGE_BBOX_EN
            3'd4:    result_s = hit_s ? BOX_COLOR : bin_s;
`endif
            default: result_s = pix1_r;
        endcase
    end

    // Three register stages: input capture, transform result, output.
    always_ff @(posedge clk) begin
        if (rst) begin
            pix1_r <= '0; luma1_r <= '0; mode1_r <= 3'd0;
            de1_r <= 1'b0; hs1_r <= 1'b0; vs1_r <= 1'b0;
            pix2_r <= '0; de2_r <= 1'b0; hs2_r <= 1'b0; vs2_r <= 1'b0;
            pixel_out <= '0; de_out <= 1'b0; h_sync_out <= 1'b0; v_sync_out <= 1'b0;
        end else begin
            pix1_r <= pixel_in; luma1_r <= luma0_s; mode1_r <= mode0_s;
            de1_r <= de_in; hs1_r <= h_sync_in; vs1_r <= v_sync_in;
            pix2_r <= result_s; de2_r <= de1_r; hs2_r <= hs1_r; vs2_r <= vs1_r;
            pixel_out <= pix2_r; de_out <= de2_r; h_sync_out <= hs2_r; v_sync_out <= vs2_r;
        end
    end
endmodule
